// File: rtl/status_cond_unit.sv
// Status/condition unit: holds the committed NZCV flags, evaluates the ARM
// condition field of the decode-stage instruction, and requests a one-cycle
// decode stall on a flag hazard when EXE-stage forwarding is disabled.
// Flag bit order everywhere: [3]=Z, [2]=C, [1]=N, [0]=V.
module status_cond_unit #(
  parameter bit FORWARD   = 1'b1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 exe_valid,
  input  logic                 exe_s,
  input  logic [3:0]           exe_sr,
  input  logic                 freeze,
  input  logic                 flush,
  input  logic                 id_valid,
  input  logic [3:0]           id_cond,
  output logic [3:0]           sr,
  output logic                 carry,
  output logic                 cond_pass,
  output logic                 hazard_stall,
  output logic [CNT_WIDTH-1:0] commit_cnt
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [3:0] COND_AL = 4'b1110;

  state_t     state, state_next;
  logic       commit;
  logic [3:0] flags;
  logic       flag_z, flag_c, flag_n, flag_v;
  logic       stall_now;
  logic       stall_q;

  assign commit = exe_valid & exe_s & ~freeze & ~flush;
  assign carry  = sr[2];

  // Effective flags for the condition check: bypass the ALU status only when forwarding is on.
  always_comb begin
    flags = sr;
    if (FORWARD && commit) flags = exe_sr;
  end

  assign flag_z = flags[3];
  assign flag_c = flags[2];
  assign flag_n = flags[1];
  assign flag_v = flags[0];

  // Decode the ARM condition field against the effective flags.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cond_pass = 1'b0;
    if (id_valid) begin
      unique case (id_cond)
        4'b0000: cond_pass = flag_z;
        4'b0001: cond_pass = ~flag_z;
        4'b0010: cond_pass = flag_c;
        4'b0011: cond_pass = ~flag_c;
        4'b0100: cond_pass = flag_n;
        4'b0101: cond_pass = ~flag_n;
        4'b0110: cond_pass = flag_v;
        4'b0111: cond_pass = ~flag_v;
        4'b1000: cond_pass = flag_c & ~flag_z;
        4'b1001: cond_pass = ~flag_c | flag_z;
        4'b1010: cond_pass = (flag_n == flag_v);
        4'b1011: cond_pass = (flag_n != flag_v);
        4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
        4'b1101: cond_pass = flag_z | (flag_n != flag_v);
        4'b1110: cond_pass = 1'b1;
        default: cond_pass = 1'b0;
      endcase
    end
  end

  // Committed flags and the commit event counter (wraps naturally).
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      sr         <= 4'b0000;
      commit_cnt <= '0;
    end else if (commit) begin
      sr         <= exe_sr;
      commit_cnt <= commit_cnt + CNT_WIDTH'(1);
    end
  end

  // Hazard FSM next state and raw stall request; inert when forwarding is enabled.
  always_comb begin
    stall_now  = 1'b0;
    state_next = state;
    if (!FORWARD) begin
      if (state == ST_IDLE)
        stall_now = commit & id_valid & (id_cond != COND_AL);
      if (!freeze) begin
        if (flush)               state_next = ST_IDLE;
        else if (state == ST_WAIT) state_next = ST_IDLE;
        else if (stall_now)      state_next = ST_WAIT;
      end
    end
  end

  // Hazard state register plus the last unfrozen stall value, held across a freeze.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      stall_q <= 1'b0;
    end else if (!freeze) begin
      state   <= state_next;
      stall_q <= stall_now;
    end
  end

  assign hazard_stall = ~rst & (freeze ? stall_q : stall_now);

endmodule
